// File: rtl/path_pkg.sv
// Shared constants and state encoding for the path tracer.
// The node ID width is shared with the dijkstra planner's prev table.
package path_pkg;

  localparam int N_NODES = 64;
  localparam int NODE_W  = 8;
  localparam int MAX_LEN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PUSH,
    ST_FETCH,
    ST_WAIT,
    ST_EMIT,
    ST_FIN
  } tracer_state_t;

endpackage

// File: rtl/path_lifo.sv
// Hop stack: synchronous push/pop with synchronous clear.
// A push when full and a pop when empty are ignored. A push takes priority over a pop.
module path_lifo
  import path_pkg::*;
#(
  parameter int DEPTH = MAX_LEN,
  parameter int WIDTH = NODE_W,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] w_wr_idx;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full && !i_clr;
  assign w_do_pop  = i_pop && !o_empty && !i_clr && !i_push;
  assign w_wr_idx  = IDX_W'(r_count);
  assign w_top_idx = IDX_W'(r_count - 1'b1);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + 1'b1;
    end else if (w_do_pop) begin
      r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage has no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_top   = o_empty ? '0 : r_mem[w_top_idx];

endmodule

// File: rtl/path_tracer.sv
// Walks the planner's predecessor table from goal back to source, then streams
// the buffered waypoints source-first over a valid/ready interface.
module path_tracer
  import path_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [NODE_W-1:0] i_src_node,
  input  logic [NODE_W-1:0] i_goal_node,
  output logic [NODE_W-1:0] o_prev_addr,
  output logic              o_prev_rd,
  input  logic [NODE_W-1:0] i_prev_data,
  output logic              o_wp_valid,
  input  logic              i_wp_ready,
  output logic [NODE_W-1:0] o_wp_node,
  output logic              o_wp_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [NODE_W:0] NODE_LIM = (NODE_W + 1)'(N_NODES);

  function automatic logic node_ok(input logic [NODE_W-1:0] n);
    return {1'b0, n} < NODE_LIM;
  endfunction

  tracer_state_t     r_state, w_state_nxt;
  logic [NODE_W-1:0] r_cur, w_cur_nxt;
  logic [NODE_W-1:0] r_src, w_src_nxt;
  logic              r_error, w_error_nxt;

  logic              w_push, w_pop, w_clr;
  logic [NODE_W-1:0] w_lifo_top;
  logic [CNT_W-1:0]  w_lifo_count;
  logic              w_lifo_full, w_lifo_empty;

  path_lifo #(.DEPTH(MAX_LEN), .WIDTH(NODE_W)) u_lifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_cur),
    .o_top   (w_lifo_top),
    .o_count (w_lifo_count),
    .o_full  (w_lifo_full),
    .o_empty (w_lifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cur   <= '0;
      r_src   <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cur   <= w_cur_nxt;
      r_src   <= w_src_nxt;
      r_error <= w_error_nxt;
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_src_nxt   = r_src;
    w_error_nxt = r_error;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_clr       = 1'b0;
    o_prev_rd   = 1'b0;
    o_wp_valid  = 1'b0;
    o_wp_node   = '0;
    o_wp_last   = 1'b0;
    o_done      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_src_nxt = i_src_node;
          w_cur_nxt = i_goal_node;
          w_clr     = 1'b1;
          if (!node_ok(i_src_node) || !node_ok(i_goal_node)) begin
            w_error_nxt = 1'b1;
            w_state_nxt = ST_FIN;
          end else begin
            w_error_nxt = 1'b0;
            w_state_nxt = ST_PUSH;
          end
        end
      end
      ST_PUSH: begin
        w_push = !w_lifo_full;
        if (r_cur == r_src) begin
          w_state_nxt = ST_EMIT;
        end else if (w_lifo_count == CNT_W'(MAX_LEN - 1)) begin
          // This push fills the stack without reaching the source: loop or overlong path.
          w_error_nxt = 1'b1;
          w_state_nxt = ST_FIN;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_prev_rd   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A self-predecessor is the planner's marker for an unreachable node.
        if (!node_ok(i_prev_data) || (i_prev_data == r_cur)) begin
          w_error_nxt = 1'b1;
          w_state_nxt = ST_FIN;
        end else begin
          w_cur_nxt   = i_prev_data;
          w_state_nxt = ST_PUSH;
        end
      end
      ST_EMIT: begin
        o_wp_valid = !w_lifo_empty;
        o_wp_node  = w_lifo_top;
        o_wp_last  = (w_lifo_count == CNT_W'(1));
        if (o_wp_valid && i_wp_ready) begin
          w_pop = 1'b1;
          if (o_wp_last) begin
            w_state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_prev_addr = r_cur;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_error     = r_error;

endmodule

// File: tb/tb_path_tracer.sv
// Scoreboard bench for path_tracer: a behavioural prev table answers reads,
// expected read addresses and waypoints are queued per job and popped as they appear.
module tb_path_tracer;
  import path_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_start;
  logic [NODE_W-1:0] i_src_node, i_goal_node;
  logic [NODE_W-1:0] o_prev_addr;
  logic              o_prev_rd;
  logic [NODE_W-1:0] i_prev_data = '0;
  logic              o_wp_valid;
  logic              i_wp_ready;
  logic [NODE_W-1:0] o_wp_node;
  logic              o_wp_last;
  logic              o_busy, o_done, o_error;

  always #5 clk = ~clk;

  path_tracer dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_src_node  (i_src_node),
    .i_goal_node (i_goal_node),
    .o_prev_addr (o_prev_addr),
    .o_prev_rd   (o_prev_rd),
    .i_prev_data (i_prev_data),
    .o_wp_valid  (o_wp_valid),
    .i_wp_ready  (i_wp_ready),
    .o_wp_node   (o_wp_node),
    .o_wp_last   (o_wp_last),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error)
  );

  typedef struct packed {
    logic [NODE_W-1:0] node;
    logic              last;
  } beat_t;

  logic [NODE_W-1:0] prev_mem [256];
  beat_t             exp_beats [$];
  logic [NODE_W-1:0] exp_reads [$];
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc = 0;
  int                last_cyc = 0;
  bit                beat_seen = 1'b0;
  bit                was_stall = 1'b0;
  beat_t             held;
  int                stall_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predecessor table with one cycle of read latency.
  always @(posedge clk) begin
    if (o_prev_rd) i_prev_data <= prev_mem[o_prev_addr];
  end

  always @(negedge clk) begin
    beat_t b;
    logic [NODE_W-1:0] a;
    cyc++;
    if (rst) begin
      was_stall = 1'b0;
      beat_seen = 1'b0;
    end else begin
      if (was_stall) begin
        check("hold_valid", o_wp_valid, 1);
        check("hold_node", o_wp_node, held.node);
        check("hold_last", o_wp_last, held.last);
      end
      was_stall = o_wp_valid && !i_wp_ready;
      held      = '{node: o_wp_node, last: o_wp_last};
      if (was_stall) stall_cnt++;
      if (o_wp_valid && i_wp_ready) begin
        if (exp_beats.size() == 0) begin
          check("extra_beat", exp_beats.size(), 1);
        end else begin
          b = exp_beats.pop_front();
          check("beat_node", o_wp_node, b.node);
          check("beat_last", o_wp_last, b.last);
          if (o_wp_last) begin
            last_cyc  = cyc;
            beat_seen = 1'b1;
          end
        end
      end
      if (o_prev_rd) begin
        if (exp_reads.size() == 0) begin
          check("extra_read", exp_reads.size(), 1);
        end else begin
          a = exp_reads.pop_front();
          check("read_addr", o_prev_addr, a);
        end
      end
      if (o_done && beat_seen) begin
        check("done_after_last", cyc - last_cyc, 1);
        beat_seen = 1'b0;
      end
    end
  end

  task automatic init_mem();
    for (int i = 0; i < 256; i++) prev_mem[i] = NODE_W'(i);
  endtask

  // Path 0 -> 1 -> 3 -> 5.
  task automatic set_normal();
    init_mem();
    prev_mem[5] = 3;
    prev_mem[3] = 1;
    prev_mem[1] = 0;
    exp_reads = '{8'd5, 8'd3, 8'd1};
    exp_beats = '{'{node: 8'd0, last: 1'b0}, '{node: 8'd1, last: 1'b0},
                  '{node: 8'd3, last: 1'b0}, '{node: 8'd5, last: 1'b1}};
  endtask

  task automatic chk_reset_vals();
    check("rst_prev_addr", o_prev_addr, 0);
    check("rst_prev_rd", o_prev_rd, 0);
    check("rst_wp_valid", o_wp_valid, 0);
    check("rst_wp_node", o_wp_node, 0);
    check("rst_wp_last", o_wp_last, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
  endtask

  task automatic run_job(input logic [NODE_W-1:0] s, input logic [NODE_W-1:0] g,
                         input bit exp_err, input int exp_lat, input bit bp, input bit spur);
    int n;
    @(posedge clk); #2;
    i_src_node  = s;
    i_goal_node = g;
    i_start     = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    if (spur) begin
      // A second request while busy must not disturb the running job.
      i_src_node  = 8'd7;
      i_goal_node = 8'd7;
      i_start     = 1'b1;
    end
    if (exp_lat > 0) begin
      n = 0;
      while (n < 300) begin
        @(posedge clk); #1;
        n++;
        i_start = 1'b0;
        if (o_wp_valid) break;
      end
      check("first_valid_lat", n, exp_lat);
    end
    i_start = 1'b0;
    if (bp) begin
      n = 0;
      while (!(o_wp_valid && o_wp_node == 8'd1) && n < 50) begin
        @(posedge clk); #2;
        n++;
      end
      check("bp_node1_seen", o_wp_node, 1);
      i_wp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 i_wp_ready = 1'b1;
    end
    n = 0;
    while (!o_done && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", o_done, 1);
    check("error_at_done", o_error, exp_err);
    check("no_valid_at_done", o_wp_valid, 0);
    @(posedge clk); #1;
    check("done_one_cycle", o_done, 0);
    check("idle_not_busy", o_busy, 0);
    check("error_held", o_error, exp_err);
    check("beats_left", exp_beats.size(), 0);
    check("reads_left", exp_reads.size(), 0);
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    i_start     = 1'b0;
    i_src_node  = '0;
    i_goal_node = '0;
    i_wp_ready  = 1'b1;
    init_mem();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals();
    rst = 1'b0;

    set_normal();
    run_job(8'd0, 8'd5, 1'b0, 10, 1'b0, 1'b1);

    init_mem();
    prev_mem[9] = 0;
    prev_mem[0] = 0;
    exp_reads = '{8'd9, 8'd0};
    run_job(8'd2, 8'd9, 1'b1, 0, 1'b0, 1'b0);

    init_mem();
    exp_beats = '{'{node: 8'd7, last: 1'b1}};
    run_job(8'd7, 8'd7, 1'b0, 1, 1'b0, 1'b0);

    set_normal();
    stall_cnt = 0;
    run_job(8'd0, 8'd5, 1'b0, 10, 1'b1, 1'b0);
    check("bp_stall_cycles", stall_cnt, 3);

    init_mem();
    prev_mem[4] = 5;
    prev_mem[5] = 4;
    for (int i = 1; i <= 63; i++) exp_reads.push_back((i % 2 == 1) ? 8'd4 : 8'd5);
    run_job(8'd0, 8'd4, 1'b1, 0, 1'b0, 1'b0);

    run_job(8'd0, 8'd70, 1'b1, 0, 1'b0, 1'b0);

    set_normal();
    run_job(8'd0, 8'd5, 1'b0, 10, 1'b0, 1'b0);

    // Reset while a beat is held under backpressure.
    set_normal();
    i_wp_ready = 1'b0;
    @(posedge clk); #2;
    i_src_node  = 8'd0;
    i_goal_node = 8'd5;
    i_start     = 1'b1;
    @(posedge clk); #2;
    i_start = 1'b0;
    n = 0;
    while (!o_wp_valid && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    check("rst_reached_emit", o_wp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    rst = 1'b0;
    exp_beats.delete();
    exp_reads.delete();
    i_wp_ready = 1'b1;

    set_normal();
    run_job(8'd0, 8'd5, 1'b0, 10, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
